// File: rtl/regfile_write_arbiter.sv
// ---------------------------------------------------------------------------
// regfile_write_arbiter
//
// Purpose:
//   Shares the register file's single write port between pipeline writeback
//   (WB) and the multiply/divide unit (MDU).
//   - WB always has priority and is never back-pressured.
//   - MDU results enter a 1-entry holding buffer through a valid/ready
//     handshake. A held result is written whenever WB leaves the port free.
//   - If WB blocks a held result for MAX_WAIT cycles, stall_req is raised so
//     that the pipeline inserts a WB bubble.
//   - A 32-bit scoreboard tracks registers with an outstanding MDU write.
//     It drives a decode-stage read-hazard flag.
//
// Optional feature (macro REGARB_BYPASS_EN):
//   When the macro is defined, an MDU result offered while the buffer is
//   empty and WB is idle is written straight to the register file in the
//   same cycle. The buffer is not loaded in that case.
//   When the macro is undefined, every MDU result passes through the buffer.
//
// Parameters:
//   MAX_WAIT  cycles a held result may be blocked by WB before stall_req (1..15)
//   WAIT_W    width of the wait counter
//
// Ports:
//   clk           system clock, all state updates on posedge
//   rst_n         asynchronous active-low reset
//   wb_we/wb_reg/wb_data        writeback write request
//   mdu_valid/mdu_ready         MDU result handshake
//   mdu_reg/mdu_data            MDU result destination and data
//   issue_valid/issue_reg       MDU operation issued, and its destination
//   rd_reg1/rd_reg2             decode-stage read indices
//   rd_hazard     a read index has a pending MDU write
//   stall_req     request for a WB bubble (registered, high in FORCE)
//   rf_we/rf_wreg/rf_wdata      register file write port
//   pending_mask  scoreboard, bit i = register i has a pending MDU write
//
// States:
//   state   | meaning
//   --------+-------------------------------------------------------------
//   S_EMPTY | holding buffer empty, mdu_ready=1
//   S_HELD  | buffer holds a result waiting for a free write port
//   S_FORCE | held result starved by WB, stall_req asserted until drained
// ---------------------------------------------------------------------------
module regfile_write_arbiter #(
    parameter int MAX_WAIT = 4,
    parameter int WAIT_W   = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        wb_we,
    input  logic [4:0]  wb_reg,
    input  logic [31:0] wb_data,
    input  logic        mdu_valid,
    output logic        mdu_ready,
    input  logic [4:0]  mdu_reg,
    input  logic [31:0] mdu_data,
    input  logic        issue_valid,
    input  logic [4:0]  issue_reg,
    input  logic [4:0]  rd_reg1,
    input  logic [4:0]  rd_reg2,
    output logic        rd_hazard,
    output logic        stall_req,
    output logic        rf_we,
    output logic [4:0]  rf_wreg,
    output logic [31:0] rf_wdata,
    output logic [31:0] pending_mask
);

    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_HELD  = 2'd1,
        S_FORCE = 2'd2
    } state_t;

    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MAX_WAIT - 1);
    localparam logic [WAIT_W-1:0] WAIT_SAT  = WAIT_W'(MAX_WAIT);

    state_t              state_q;
    state_t              state_nx;
    logic [WAIT_W-1:0]   wait_q;
    logic [WAIT_W-1:0]   wait_nx;
    logic [4:0]          buf_reg_q;
    logic [31:0]         buf_data_q;
    logic [31:0]         pending_q;
    logic [31:0]         pending_nx;
    logic [31:0]         set_mask;
    logic [31:0]         clr_mask;

    logic wb_active;
    logic buf_full;
    logic drain;
    logic blocked;
    logic bypass;
    logic capture;

    // Register 0 is a sink: a WB write to it does not claim the port.
    assign wb_active = wb_we & (wb_reg != 5'd0);
    assign buf_full  = (state_q != S_EMPTY);
    assign drain     = buf_full & ~wb_active;
    assign blocked   = buf_full & wb_active;

`ifdef REGARB_BYPASS_EN
    assign bypass    = ~buf_full & ~wb_active & mdu_valid;
`else
    assign bypass    = 1'b0;
`endif

    // Ready is derived purely from registered state. A bypassed result
    // never loads the buffer.
    assign mdu_ready = ~buf_full;
    assign capture   = mdu_valid & ~buf_full & ~bypass;

    assign stall_req    = (state_q == S_FORCE);
    assign pending_mask = pending_q;
    assign rd_hazard    = pending_q[rd_reg1] | pending_q[rd_reg2];

    // ------------------------------------------------------------------
    // FSM and wait counter
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_EMPTY;
            wait_q  <= '0;
        end else begin
            state_q <= state_nx;
            wait_q  <= wait_nx;
        end
    end

    always_comb begin
        state_nx = state_q;
        wait_nx  = wait_q;
        case (state_q)
            S_EMPTY: begin
                wait_nx = '0;
                if (capture) begin
                    state_nx = S_HELD;
                end
            end
            S_HELD: begin
                if (drain) begin
                    state_nx = S_EMPTY;
                    wait_nx  = '0;
                end else if (blocked) begin
                    if (wait_q == WAIT_LAST) begin
                        state_nx = S_FORCE;
                    end
                    if (wait_q != WAIT_SAT) begin
                        wait_nx = wait_q + 1'b1;
                    end
                end
            end
            S_FORCE: begin
                // WB keeps priority even if the pipeline ignores stall_req.
                if (drain) begin
                    state_nx = S_EMPTY;
                    wait_nx  = '0;
                end else if (blocked && (wait_q != WAIT_SAT)) begin
                    wait_nx = wait_q + 1'b1;
                end
            end
            default: begin
                state_nx = S_EMPTY;
                wait_nx  = '0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Holding buffer
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            buf_reg_q  <= 5'd0;
            buf_data_q <= 32'd0;
        end else if (capture) begin
            buf_reg_q  <= mdu_reg;
            buf_data_q <= mdu_data;
        end else if (drain) begin
            buf_reg_q  <= 5'd0;
            buf_data_q <= 32'd0;
        end
    end

    // ------------------------------------------------------------------
    // Write port select. This path is combinational because the register
    // file commits on the falling edge of the same cycle.
    // ------------------------------------------------------------------
    always_comb begin
        rf_we    = 1'b0;
        rf_wreg  = 5'd0;
        rf_wdata = 32'd0;
        if (wb_active) begin
            rf_we    = 1'b1;
            rf_wreg  = wb_reg;
            rf_wdata = wb_data;
        end else if (buf_full) begin
            rf_we    = (buf_reg_q != 5'd0);
            rf_wreg  = buf_reg_q;
            rf_wdata = buf_data_q;
        end
`ifdef REGARB_BYPASS_EN
        else if (bypass) begin
            rf_we    = (mdu_reg != 5'd0);
            rf_wreg  = mdu_reg;
            rf_wdata = mdu_data;
        end
`endif
    end

    // ------------------------------------------------------------------
    // Pending-write scoreboard. Set beats clear on the same register
    // because the issue is the younger operation. Bit 0 is never set.
    // ------------------------------------------------------------------
    always_comb begin
        set_mask = 32'd0;
        clr_mask = 32'd0;
        if (issue_valid && (issue_reg != 5'd0)) begin
            set_mask[issue_reg] = 1'b1;
        end
        if (drain) begin
            clr_mask[buf_reg_q] = 1'b1;
        end
        if (bypass) begin
            clr_mask[mdu_reg] = 1'b1;
        end
        pending_nx = ((pending_q & ~clr_mask) | set_mask) & ~32'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending_q <= 32'd0;
        end else begin
            pending_q <= pending_nx;
        end
    end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
module tb_regfile_write_arbiter;

    logic        clk;
    logic        rst_n;
    logic        wb_we;
    logic [4:0]  wb_reg;
    logic [31:0] wb_data;
    logic        mdu_valid;
    logic        mdu_ready;
    logic [4:0]  mdu_reg;
    logic [31:0] mdu_data;
    logic        issue_valid;
    logic [4:0]  issue_reg;
    logic [4:0]  rd_reg1;
    logic [4:0]  rd_reg2;
    logic        rd_hazard;
    logic        stall_req;
    logic        rf_we;
    logic [4:0]  rf_wreg;
    logic [31:0] rf_wdata;
    logic [31:0] pending_mask;

    int n_checks;
    int n_fail;

    regfile_write_arbiter #(.MAX_WAIT(4), .WAIT_W(4)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .wb_we        (wb_we),
        .wb_reg       (wb_reg),
        .wb_data      (wb_data),
        .mdu_valid    (mdu_valid),
        .mdu_ready    (mdu_ready),
        .mdu_reg      (mdu_reg),
        .mdu_data     (mdu_data),
        .issue_valid  (issue_valid),
        .issue_reg    (issue_reg),
        .rd_reg1      (rd_reg1),
        .rd_reg2      (rd_reg2),
        .rd_hazard    (rd_hazard),
        .stall_req    (stall_req),
        .rf_we        (rf_we),
        .rf_wreg      (rf_wreg),
        .rf_wdata     (rf_wdata),
        .pending_mask (pending_mask)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        wb_we;
        logic [4:0]  wb_reg;
        logic [31:0] wb_data;
        logic        mdu_valid;
        logic [4:0]  mdu_reg;
        logic [31:0] mdu_data;
        logic        issue_valid;
        logic [4:0]  issue_reg;
        logic [4:0]  rd1;
        logic [4:0]  rd2;
        logic        e_we;
        logic [4:0]  e_wreg;
        logic [31:0] e_wdata;
        logic        e_ready;
        logic        e_haz;
        logic        e_stall;
        logic [31:0] e_pm;
    } vec_t;

    vec_t tbl[16];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic drv(input logic we, input logic [4:0] wr, input logic [31:0] wd,
                       input logic mv, input logic [4:0] mr, input logic [31:0] md,
                       input logic iv, input logic [4:0] ir);
        wb_we       = we;
        wb_reg      = wr;
        wb_data     = wd;
        mdu_valid   = mv;
        mdu_reg     = mr;
        mdu_data    = md;
        issue_valid = iv;
        issue_reg   = ir;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        drv(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0);
        rd_reg1 = 5'd0;
        rd_reg2 = 5'd0;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        next_cycle();
    endtask

    // Issuing to a register that is still pending is illegal unless that
    // register is being written back from the buffer in the same cycle.
    always @(posedge clk) begin
        if (rst_n && issue_valid && (issue_reg != 5'd0)) begin
            n_checks++;
            if (pending_mask[issue_reg] && !(rf_we && (rf_wreg == issue_reg))) begin
                n_fail++;
                $display("FAIL issue_to_pending: reg %0d already pending, mask 0x%08h", issue_reg, pending_mask);
            end
        end
    end

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst_n    = 1'b0;
        drv(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0);
        rd_reg1 = 5'd0;
        rd_reg2 = 5'd0;

        //            wb_we  wb_reg  wb_data       mv    mreg   mdata         iv    ir     rd1    rd2     we    wreg   wdata         rdy   haz   stl   pm
        tbl[0]  = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 5'd0, 5'd0,  1'b0, 5'd0, 32'h0,        1'b1, 1'b0, 1'b0, 32'h0};
        tbl[1]  = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,        1'b1, 5'd5, 5'd0, 5'd0,  1'b0, 5'd0, 32'h0,        1'b1, 1'b0, 1'b0, 32'h0};
        tbl[2]  = '{1'b0, 5'd0, 32'h0,        1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 5'd5, 5'd0,  1'b0, 5'd0, 32'h0,        1'b1, 1'b1, 1'b0, 32'h20};
        tbl[3]  = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 5'd5, 5'd0,  1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 1'b1, 1'b0, 32'h20};
        tbl[4]  = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 5'd5, 5'd0,  1'b0, 5'd0, 32'h0,        1'b1, 1'b0, 1'b0, 32'h0};
        tbl[5]  = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,        1'b1, 5'd7, 5'd0, 5'd0,  1'b0, 5'd0, 32'h0,        1'b1, 1'b0, 1'b0, 32'h0};
        tbl[6]  = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 5'd7, 5'd0,  1'b0, 5'd0, 32'h0,        1'b1, 1'b1, 1'b0, 32'h80};
        tbl[7]  = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 5'd0, 5'd3,  1'b0, 5'd0, 32'h0,        1'b1, 1'b0, 1'b0, 32'h80};
        tbl[8]  = '{1'b1, 5'd3, 32'h11,       1'b0, 5'd0, 32'h0,        1'b1, 5'd6, 5'd0, 5'd0,  1'b1, 5'd3, 32'h11,       1'b1, 1'b0, 1'b0, 32'h80};
        tbl[9]  = '{1'b1, 5'd0, 32'h22,       1'b1, 5'd6, 32'h1234,     1'b0, 5'd0, 5'd0, 5'd0,  1'b0, 5'd0, 32'h0,        1'b1, 1'b0, 1'b0, 32'hC0};
        tbl[10] = '{1'b1, 5'd0, 32'h22,       1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 5'd6, 5'd0,  1'b1, 5'd6, 32'h1234,     1'b0, 1'b1, 1'b0, 32'hC0};
        tbl[11] = '{1'b0, 5'd0, 32'h0,        1'b1, 5'd0, 32'h55,       1'b0, 5'd0, 5'd6, 5'd0,  1'b0, 5'd0, 32'h0,        1'b1, 1'b0, 1'b0, 32'h80};
        tbl[12] = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 5'd0, 5'd0,  1'b0, 5'd0, 32'h55,       1'b0, 1'b0, 1'b0, 32'h80};
        tbl[13] = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 5'd0, 5'd7,  1'b0, 5'd0, 32'h0,        1'b1, 1'b1, 1'b0, 32'h80};
        tbl[14] = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,        1'b1, 5'd0, 5'd0, 5'd0,  1'b0, 5'd0, 32'h0,        1'b1, 1'b0, 1'b0, 32'h80};
        tbl[15] = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 5'd0, 5'd0,  1'b0, 5'd0, 32'h0,        1'b1, 1'b0, 1'b0, 32'h80};

        do_reset();

`ifndef REGARB_BYPASS_EN
        // Table vectors assume every MDU result passes through the buffer.
        for (int i = 0; i < 16; i++) begin
            drv(tbl[i].wb_we, tbl[i].wb_reg, tbl[i].wb_data,
                tbl[i].mdu_valid, tbl[i].mdu_reg, tbl[i].mdu_data,
                tbl[i].issue_valid, tbl[i].issue_reg);
            rd_reg1 = tbl[i].rd1;
            rd_reg2 = tbl[i].rd2;
            @(negedge clk);
            chk($sformatf("v%0d rf_we", i),        {31'd0, rf_we},     {31'd0, tbl[i].e_we});
            chk($sformatf("v%0d rf_wreg", i),      {27'd0, rf_wreg},   {27'd0, tbl[i].e_wreg});
            chk($sformatf("v%0d rf_wdata", i),     rf_wdata,           tbl[i].e_wdata);
            chk($sformatf("v%0d mdu_ready", i),    {31'd0, mdu_ready}, {31'd0, tbl[i].e_ready});
            chk($sformatf("v%0d rd_hazard", i),    {31'd0, rd_hazard}, {31'd0, tbl[i].e_haz});
            chk($sformatf("v%0d stall_req", i),    {31'd0, stall_req}, {31'd0, tbl[i].e_stall});
            chk($sformatf("v%0d pending_mask", i), pending_mask,       tbl[i].e_pm);
            next_cycle();
        end
`else
        // Bypass: direct write of r8 with an empty buffer and WB idle.
        drv(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd8);
        next_cycle();
        drv(1'b0, 5'd0, 32'd0, 1'b1, 5'd8, 32'h8888, 1'b0, 5'd0);
        @(negedge clk);
        chk("byp rf_we",     {31'd0, rf_we},     32'd1);
        chk("byp rf_wreg",   {27'd0, rf_wreg},   32'd8);
        chk("byp rf_wdata",  rf_wdata,           32'h8888);
        chk("byp mdu_ready", {31'd0, mdu_ready}, 32'd1);
        chk("byp pm_before", pending_mask,       32'h100);
        next_cycle();
        drv(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0);
        @(negedge clk);
        chk("byp pm_after",  pending_mask,       32'h0);
        chk("byp rf_we_idle", {31'd0, rf_we},    32'd0);
        chk("byp mdu_ready2", {31'd0, mdu_ready}, 32'd1);
        next_cycle();
`endif

        // Starvation: r9 held while WB writes r2 continuously.
        do_reset();
        drv(1'b1, 5'd2, 32'hAAAA, 1'b1, 5'd9, 32'h9999, 1'b1, 5'd9);
        @(negedge clk);
        chk("stv load rf_wreg", {27'd0, rf_wreg},   32'd2);
        chk("stv load ready",   {31'd0, mdu_ready}, 32'd1);
        next_cycle();
        drv(1'b1, 5'd2, 32'hAAAA, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk($sformatf("stv c%0d rf_wreg", k),  {27'd0, rf_wreg},   32'd2);
            chk($sformatf("stv c%0d stall", k),    {31'd0, stall_req}, 32'd0);
            chk($sformatf("stv c%0d ready", k),    {31'd0, mdu_ready}, 32'd0);
            next_cycle();
        end
        // stall_req now high; WB ignores it for one cycle and keeps priority.
        @(negedge clk);
        chk("stv force stall",   {31'd0, stall_req}, 32'd1);
        chk("stv force rf_wreg", {27'd0, rf_wreg},   32'd2);
        chk("stv force pm",      pending_mask,       32'h200);
        next_cycle();
        drv(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0);
        @(negedge clk);
        chk("stv drain rf_we",    {31'd0, rf_we},     32'd1);
        chk("stv drain rf_wreg",  {27'd0, rf_wreg},   32'd9);
        chk("stv drain rf_wdata", rf_wdata,           32'h9999);
        chk("stv drain stall",    {31'd0, stall_req}, 32'd1);
        next_cycle();
        @(negedge clk);
        chk("stv after stall", {31'd0, stall_req}, 32'd0);
        chk("stv after ready", {31'd0, mdu_ready}, 32'd1);
        chk("stv after pm",    pending_mask,       32'h0);
        next_cycle();

        // Collision: re-issue to r4 in the cycle the buffer drains r4.
        do_reset();
        drv(1'b1, 5'd2, 32'h1, 1'b1, 5'd4, 32'h44, 1'b1, 5'd4);
        next_cycle();
        drv(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd4);
        @(negedge clk);
        chk("col rf_wreg", {27'd0, rf_wreg}, 32'd4);
        chk("col rf_wdata", rf_wdata,        32'h44);
        next_cycle();
        drv(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0);
        @(negedge clk);
        chk("col pm",    pending_mask,       32'h10);
        chk("col ready", {31'd0, mdu_ready}, 32'd1);
        next_cycle();

        // Reset mid-cycle with the buffer holding r8 and bits 2, 8 pending.
        do_reset();
        drv(1'b1, 5'd3, 32'h3, 1'b1, 5'd8, 32'h88, 1'b1, 5'd2);
        next_cycle();
        drv(1'b1, 5'd3, 32'h3, 1'b0, 5'd0, 32'd0, 1'b1, 5'd8);
        next_cycle();
        drv(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0);
        @(negedge clk);
        chk("rst pre pm",     pending_mask,     32'h104);
        chk("rst pre rf_wreg", {27'd0, rf_wreg}, 32'd8);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst pm",       pending_mask,       32'h0);
        chk("rst rf_we",    {31'd0, rf_we},     32'd0);
        chk("rst rf_wreg",  {27'd0, rf_wreg},   32'd0);
        chk("rst rf_wdata", rf_wdata,           32'h0);
        chk("rst stall",    {31'd0, stall_req}, 32'd0);
        chk("rst ready",    {31'd0, mdu_ready}, 32'd1);
        do_reset();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
